uart_tx: RTL and testbench

Serial UART transmitter that drains the echo FIFO and drives the `tx` line. It consumes the FIFO's show-ahead output: `fifo_data` is valid whenever `fifo_empty` is low, and a single-cycle `fifo_r_en` pops the entry. It sits directly downstream of the FIFO and is the last stage before the pad. Frame format is LSB-first: start bit, DATA_W data bits, optional parity bit, then 1 or 2 stop bits.

---
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: LSB-first serial transmitter draining a show-ahead FIFO.
// Frame: start bit, DATA_W data bits, optional parity, STOP_BITS stop bits.
module uart_tx #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_r_en,
    output logic              tx,
    output logic              busy
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t              state, state_d;
    logic [BAUD_W-1:0]   baud_cnt, baud_cnt_d;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0]   shreg, shreg_d;
    logic [DATA_W-1:0]   data_lat, data_lat_d;
    logic                tx_d;
    logic                par_bit;
    logic                baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign par_bit   = (^data_lat) ^ (PARITY == 2);
    assign busy      = (state != IDLE);

    // State, counters, data registers and the registered tx line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_lat <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            data_lat <= data_lat_d;
            tx       <= tx_d;
        end
    end

    // Next-state, counter and pop logic; tx_d is the line level for the next state.
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt + 1'b1;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        data_lat_d = data_lat;
        fifo_r_en  = 1'b0;
        tx_d       = 1'b1;

        unique case (state)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!fifo_empty && rst_n) begin
                    fifo_r_en  = 1'b1;
                    shreg_d    = fifo_data;
                    data_lat_d = fifo_data;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    shreg_d    = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            PAR: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered, so the level is chosen from the state being entered.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PAR:     tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx across four parameter sets.
// u0: div4/none/1 stop, u1: even parity, u2: odd parity, u3: div3/2 stop.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0] mem [4][16];
    logic [3:0] wp [4] = '{default: '0};
    logic [3:0] rp [4] = '{default: '0};
    int         pop_cnt [4] = '{default: 0};

    logic [7:0] fdata [4];
    logic       fempty [4];
    logic       ren [4];
    logic       txw [4];
    logic       busyw [4];

    logic tr_tx [128];
    logic tr_busy [128];
    logic tr_ren [128];

    int checks = 0;
    int failures = 0;

    localparam int DIV [4] = '{4, 4, 4, 3};
    localparam int PAR [4] = '{0, 1, 2, 0};
    localparam int STP [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            fdata[k]  = mem[k][rp[k]];
            fempty[k] = (wp[k] == rp[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ren[k]) begin
                pop_cnt[k] <= pop_cnt[k] + 1;
                if (wp[k] != rp[k]) rp[k] <= rp[k] + 4'd1;
            end
        end
    end

    uart_tx #(.CLK_DIV(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .fifo_data(fdata[0]), .fifo_empty(fempty[0]),
        .fifo_r_en(ren[0]), .tx(txw[0]), .busy(busyw[0]));
    uart_tx #(.CLK_DIV(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .fifo_data(fdata[1]), .fifo_empty(fempty[1]),
        .fifo_r_en(ren[1]), .tx(txw[1]), .busy(busyw[1]));
    uart_tx #(.CLK_DIV(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .fifo_data(fdata[2]), .fifo_empty(fempty[2]),
        .fifo_r_en(ren[2]), .tx(txw[2]), .busy(busyw[2]));
    uart_tx #(.CLK_DIV(3), .DATA_W(8), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .fifo_data(fdata[3]), .fifo_empty(fempty[3]),
        .fifo_r_en(ren[3]), .tx(txw[3]), .busy(busyw[3]));

    task automatic push(input int k, input logic [7:0] d);
        mem[k][wp[k]] = d;
        wp[k] = wp[k] + 4'd1;
    endtask

    // Record n samples, each taken 1 time unit after a rising edge.
    task automatic trace(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tr_tx[i]   = txw[k];
            tr_busy[i] = busyw[k];
            tr_ren[i]  = ren[k];
        end
    endtask

    // Expected line level at cycle i of a frame carrying d on instance k.
    function automatic logic exp_tx(input int k, input logic [7:0] d, input int i);
        int b;
        b = i / DIV[k];
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR[k] != 0 && b == 9) return (^d) ^ (PAR[k] == 2);
        return 1'b1;
    endfunction

    function automatic int flen(input int k);
        return (1 + 8 + ((PAR[k] != 0) ? 1 : 0) + STP[k]) * DIV[k];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(0, 8'h55);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (txw[k] !== 1'b1) begin
                failures++; $display("FAIL reset_tx[%0d]: got %b expected 1", k, txw[k]);
            end
            checks++;
            if (busyw[k] !== 1'b0) begin
                failures++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busyw[k]);
            end
            checks++;
            if (ren[k] !== 1'b0) begin
                failures++; $display("FAIL reset_ren[%0d]: got %b expected 0", k, ren[k]);
            end
        end
    endtask

    // Byte 0x55 pending since reset; pop happens on the first edge after release.
    task automatic test_basic_frame();
        int p;
        logic e;
        @(posedge clk);
        #1;
        p = pop_cnt[0];
        rst_n = 1'b1;
        trace(0, 45);
        for (int i = 0; i < 45; i++) begin
            e = (i < 40) ? exp_tx(0, 8'h55, i) : 1'b1;
            checks++;
            if (tr_tx[i] !== e) begin
                failures++; $display("FAIL basic_tx[%0d]: got %b expected %b", i, tr_tx[i], e);
            end
            checks++;
            if (tr_busy[i] !== (i < 40)) begin
                failures++; $display("FAIL basic_busy[%0d]: got %b expected %b", i, tr_busy[i], (i < 40));
            end
        end
        checks++;
        if (pop_cnt[0] - p !== 1) begin
            failures++; $display("FAIL basic_pops: got %0d expected 1", pop_cnt[0] - p);
        end
    endtask

    task automatic test_parity(input int k, input logic [7:0] d);
        int p;
        logic e;
        @(posedge clk);
        #1;
        p = pop_cnt[k];
        push(k, d);
        trace(k, 48);
        for (int i = 0; i < 48; i++) begin
            e = (i < 44) ? exp_tx(k, d, i) : 1'b1;
            checks++;
            if (tr_tx[i] !== e) begin
                failures++; $display("FAIL parity%0d_tx[%0d]: got %b expected %b", k, i, tr_tx[i], e);
            end
            checks++;
            if (tr_busy[i] !== (i < 44)) begin
                failures++; $display("FAIL parity%0d_busy[%0d]: got %b expected %b", k, i, tr_busy[i], (i < 44));
            end
        end
        checks++;
        if (tr_tx[37] !== 1'b1) begin
            failures++; $display("FAIL parity%0d_bit: got %b expected 1", k, tr_tx[37]);
        end
        checks++;
        if (pop_cnt[k] - p !== 1) begin
            failures++; $display("FAIL parity%0d_pops: got %0d expected 1", k, pop_cnt[k] - p);
        end
    endtask

    task automatic test_back_to_back();
        int p;
        logic [7:0] got;
        logic [7:0] want [2];
        want[0] = 8'hA5;
        want[1] = 8'h3C;
        @(posedge clk);
        #1;
        p = pop_cnt[0];
        push(0, 8'hA5);
        push(0, 8'h3C);
        trace(0, 90);
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 8; j++) got[j] = tr_tx[f*41 + 4*(1+j) + 2];
            checks++;
            if (got !== want[f]) begin
                failures++; $display("FAIL b2b_byte%0d: got %h expected %h", f, got, want[f]);
            end
            checks++;
            if (tr_tx[f*41] !== 1'b0 || tr_busy[f*41] !== 1'b1) begin
                failures++; $display("FAIL b2b_start%0d: got tx=%b busy=%b expected tx=0 busy=1", f, tr_tx[f*41], tr_busy[f*41]);
            end
        end
        checks++;
        if (tr_busy[39] !== 1'b1 || tr_tx[39] !== 1'b1) begin
            failures++; $display("FAIL b2b_last_stop: got tx=%b busy=%b expected tx=1 busy=1", tr_tx[39], tr_busy[39]);
        end
        checks++;
        if (tr_tx[40] !== 1'b1 || tr_busy[40] !== 1'b0 || tr_ren[40] !== 1'b1) begin
            failures++; $display("FAIL b2b_idle: got tx=%b busy=%b ren=%b expected 1 0 1", tr_tx[40], tr_busy[40], tr_ren[40]);
        end
        for (int i = 81; i < 90; i++) begin
            checks++;
            if (tr_busy[i] !== 1'b0 || tr_ren[i] !== 1'b0 || tr_tx[i] !== 1'b1) begin
                failures++; $display("FAIL b2b_after[%0d]: got tx=%b busy=%b ren=%b expected 1 0 0", i, tr_tx[i], tr_busy[i], tr_ren[i]);
            end
        end
        checks++;
        if (pop_cnt[0] - p !== 2) begin
            failures++; $display("FAIL b2b_pops: got %0d expected 2", pop_cnt[0] - p);
        end
    endtask

    task automatic test_empty();
        int p;
        int bad_tx = 0;
        int bad_busy = 0;
        int bad_ren = 0;
        p = pop_cnt[0];
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (txw[0] !== 1'b1) bad_tx++;
            if (busyw[0] !== 1'b0) bad_busy++;
            if (ren[0] !== 1'b0) bad_ren++;
        end
        checks++;
        if (bad_tx != 0) begin
            failures++; $display("FAIL empty_tx: got %0d low cycles expected 0", bad_tx);
        end
        checks++;
        if (bad_busy != 0) begin
            failures++; $display("FAIL empty_busy: got %0d busy cycles expected 0", bad_busy);
        end
        checks++;
        if (bad_ren != 0 || pop_cnt[0] != p) begin
            failures++; $display("FAIL empty_ren: got %0d strobes expected 0", bad_ren);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p;
        logic e;
        @(posedge clk);
        #1;
        p = pop_cnt[0];
        push(0, 8'hF0);
        trace(0, 18);
        checks++;
        if (tr_tx[17] !== 1'b0 || tr_busy[17] !== 1'b1) begin
            failures++; $display("FAIL midrst_bit3: got tx=%b busy=%b expected tx=0 busy=1", tr_tx[17], tr_busy[17]);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (txw[0] !== 1'b1) begin
            failures++; $display("FAIL midrst_tx: got %b expected 1", txw[0]);
        end
        checks++;
        if (busyw[0] !== 1'b0) begin
            failures++; $display("FAIL midrst_busy: got %b expected 0", busyw[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0, 8'h81);
        trace(0, 45);
        for (int i = 0; i < 45; i++) begin
            e = (i < 40) ? exp_tx(0, 8'h81, i) : 1'b1;
            checks++;
            if (tr_tx[i] !== e) begin
                failures++; $display("FAIL midrst_next_tx[%0d]: got %b expected %b", i, tr_tx[i], e);
            end
        end
        checks++;
        if (pop_cnt[0] - p !== 2) begin
            failures++; $display("FAIL midrst_pops: got %0d expected 2", pop_cnt[0] - p);
        end
    endtask

    task automatic test_two_stop_bits();
        logic e;
        @(posedge clk);
        #1;
        push(3, 8'hFF);
        push(3, 8'hFF);
        trace(3, 40);
        for (int i = 0; i < 33; i++) begin
            e = exp_tx(3, 8'hFF, i);
            checks++;
            if (tr_tx[i] !== e || tr_busy[i] !== 1'b1) begin
                failures++; $display("FAIL stop2_frame[%0d]: got tx=%b busy=%b expected tx=%b busy=1", i, tr_tx[i], tr_busy[i], e);
            end
        end
        checks++;
        if (flen(3) !== 33) begin
            failures++; $display("FAIL stop2_len: got %0d expected 33", flen(3));
        end
        checks++;
        if (tr_tx[33] !== 1'b1 || tr_busy[33] !== 1'b0 || tr_ren[33] !== 1'b1) begin
            failures++; $display("FAIL stop2_idle: got tx=%b busy=%b ren=%b expected 1 0 1", tr_tx[33], tr_busy[33], tr_ren[33]);
        end
        checks++;
        if (tr_tx[34] !== 1'b0 || tr_busy[34] !== 1'b1) begin
            failures++; $display("FAIL stop2_next_start: got tx=%b busy=%b expected tx=0 busy=1", tr_tx[34], tr_busy[34]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity(1, 8'h07);
        test_parity(2, 8'h00);
        test_back_to_back();
        test_empty();
        test_reset_mid_frame();
        test_two_stop_bits();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
